// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if -- byte-wide instruction memory read bus.
//
// Handshake: the fetch unit (master) holds mem_rd=1 with a stable mem_addr
// for as long as it wants the byte at that address. The memory (slave)
// answers with mem_ready=1 and mem_data valid in the same cycle. A byte
// is transferred on every rising CLK edge where mem_rd && mem_ready.
// While mem_rd=0, mem_ready and mem_data are ignored.
//
// Signals:
//   mem_addr  [31:0]  master -> slave  byte address
//   mem_rd            master -> slave  read strobe
//   mem_data  [7:0]   slave -> master  returned byte
//   mem_ready         slave -> master  byte-valid acknowledge
interface instr_fetch_unit_if;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_data;
  logic        mem_ready;

  modport master (output mem_addr, output mem_rd, input mem_data, input mem_ready);
  modport slave  (input mem_addr, input mem_rd, output mem_data, output mem_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit -- assembles a 32-bit big-endian instruction word from
// four byte reads of a byte-wide instruction memory.
//
// Optional feature: define FETCH_ALIGN_CHECK_EN to reject fetches whose
// pc_addr is not word aligned (goes straight to the error pulse, no read).
//
// Ports:
//   CLK, Reset          clock, asynchronous active-high reset
//   pc_addr  [31:0]     address of instruction to fetch
//   fetch_req           start a fetch (only sampled while idle)
//   mem                 memory read bus (master side)
//   instr    [31:0]     last successfully fetched instruction
//   instr_valid         one-cycle pulse when instr was just updated
//   busy                high whenever a fetch is in progress
//   fetch_err           one-cycle pulse when a fetch was aborted
//   dbg_state [1:0]     current FSM state (0 idle, 1 read, 2 done, 3 err)
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [31:0]               pc_addr,
  input  logic                      fetch_req,
  instr_fetch_unit_if.master        mem,
  output logic [31:0]               instr,
  output logic                      instr_valid,
  output logic                      busy,
  output logic                      fetch_err,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  // Timeout fires on the edge where the wait counter would reach TIMEOUT.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [31:0] base;
  logic [1:0]  idx;
  logic [7:0]  wait_cnt;
  logic [31:0] shadow;
  logic [31:0] addr_q;
  logic        accept;

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (fetch_req) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc_addr[1:0] != 2'b00) state_nxt = S_ERR;
          else                       state_nxt = S_READ;
`else
          state_nxt = S_READ;
`endif
        end
      end
      S_READ: begin
        if (mem.mem_ready) begin
          if (idx == 2'd3) state_nxt = S_DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt = S_ERR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept = (state == S_IDLE) && (state_nxt == S_READ);

  // Datapath: partial bytes go to shadow; instr only changes on completion,
  // so an aborted fetch leaves the previous instruction intact.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      base     <= '0;
      idx      <= '0;
      wait_cnt <= '0;
      shadow   <= '0;
      instr    <= '0;
      addr_q   <= '0;
    end else if (accept) begin
      base     <= pc_addr;
      idx      <= '0;
      wait_cnt <= '0;
      addr_q   <= pc_addr;
    end else if (state == S_READ) begin
      if (mem.mem_ready) begin
        wait_cnt <= '0;
        case (idx)
          2'd0:    shadow[31:24] <= mem.mem_data;
          2'd1:    shadow[23:16] <= mem.mem_data;
          2'd2:    shadow[15:8]  <= mem.mem_data;
          default: shadow[7:0]   <= mem.mem_data;
        endcase
        if (idx == 2'd3) begin
          // Byte 3 arrives this edge, so merge it directly from the bus.
          instr <= {shadow[31:8], mem.mem_data};
        end else begin
          idx    <= idx + 2'd1;
          addr_q <= base + {30'd0, idx} + 32'd1;
        end
      end else begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  // Outputs decoded from registered state; mem_addr holds outside READ.
  always_comb begin
    mem.mem_rd   = (state == S_READ);
    mem.mem_addr = addr_q;
    instr_valid  = (state == S_DONE);
    fetch_err    = (state == S_ERR);
    busy         = (state != S_IDLE);
    dbg_state    = state;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int TIMEOUT = 15;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        Reset;
  logic [31:0] pc_addr;
  logic        fetch_req;
  logic [31:0] instr;
  logic        instr_valid;
  logic        busy;
  logic        fetch_err;
  logic [1:0]  dbg_state;

  instr_fetch_unit_if bus ();

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .CLK         (CLK),
    .Reset       (Reset),
    .pc_addr     (pc_addr),
    .fetch_req   (fetch_req),
    .mem         (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .busy        (busy),
    .fetch_err   (fetch_err),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_instr = '0;  // last completed word
  logic [31:0] model_addr  = '0;  // last address driven on the bus
  int          plan[4];           // ready-low cycles before each byte

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rd"}, bus.mem_rd, 0);
    check({tag, "_valid"}, instr_valid, 0);
    check({tag, "_err"}, fetch_err, 0);
    check({tag, "_instr"}, instr, model_instr);
    check({tag, "_addr"}, bus.mem_addr, model_addr);
  endtask

  // ---------------- driver: one complete fetch ----------------
  // word is the memory content at pc..pc+3 in big-endian order.
  task automatic fetch(input logic [31:0] pc, input logic [31:0] word);
    logic [31:0] a;
    logic [31:0] exp_w;
    int idx;
    int w;
    bit err;
    bit align_err;
    @(negedge CLK);
    pc_addr        = pc;
    fetch_req      = 1'b1;
    bus.mem_ready  = 1'b0;
    @(posedge CLK);
    align_err = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    align_err = (pc[1:0] != 2'b00);
`endif
    err = align_err;
    if (!align_err) exp_q.push_back(word);
    idx = 0;
    while (!err && idx < 4) begin
      w = 0;
      forever begin
        @(negedge CLK);
        fetch_req = 1'($urandom_range(0, 1));  // must be ignored while busy
        if (w == TIMEOUT) begin
          err = 1'b1;
          break;
        end
        a = pc + 32'(idx);
        check("rd_in_read", bus.mem_rd, 1);
        check("addr_in_read", bus.mem_addr, a);
        check("busy_in_read", busy, 1);
        model_addr = a;
        if (w < plan[idx]) begin
          bus.mem_ready = 1'b0;
          bus.mem_data  = 8'($urandom);
          w++;
          @(posedge CLK);
        end else begin
          bus.mem_ready = 1'b1;
          bus.mem_data  = word[31 - 8*idx -: 8];
          @(posedge CLK);
          break;
        end
      end
      if (!err) idx++;
    end
    if (align_err || !err) @(negedge CLK);
    fetch_req     = 1'($urandom_range(0, 1));  // ignored in DONE/ERR
    bus.mem_ready = 1'b0;
    if (err) begin
      check("err_pulse", fetch_err, 1);
      check("valid_in_err", instr_valid, 0);
      check("instr_held", instr, model_instr);
      if (!align_err) void'(exp_q.pop_back());
    end else begin
      check("valid_pulse", instr_valid, 1);
      check("err_in_done", fetch_err, 0);
      exp_w = exp_q.pop_front();
      check("instr_word", instr, exp_w);
      model_instr = exp_w;
    end
    check("busy_at_end", busy, 1);
    check("rd_at_end", bus.mem_rd, 0);
    check("addr_at_end", bus.mem_addr, model_addr);
    @(negedge CLK);
    check_idle("after1");
    fetch_req = 1'b0;
    @(negedge CLK);
    check_idle("after2");
  endtask

  task automatic set_plan(input int p0, input int p1, input int p2, input int p3);
    plan[0] = p0; plan[1] = p1; plan[2] = p2; plan[3] = p3;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    Reset         = 1'b0;
    fetch_req     = 1'b0;
    pc_addr       = '0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = '0;
    #2 Reset = 1'b1;
    #1 check_idle("reset");
    check("reset_state", dbg_state, 0);
    repeat (2) @(negedge CLK);
    Reset = 1'b0;

    // Basic fetch, zero wait states.
    set_plan(0, 0, 0, 0);
    fetch(32'h0000_0100, 32'h8C01_0004);

    // Address wrap at top of memory.
    fetch(32'hFFFF_FFFE, 32'h1234_5678);

    // Misaligned address (fetched normally unless the align check is built in).
    fetch(32'h0000_0102, 32'hCAFE_F00D);

    // Three wait cycles before each byte.
    set_plan(3, 3, 3, 3);
    fetch(32'h0000_0200, 32'hDEAD_BEEF);

    // Memory never answers: timeout, instr keeps last word.
    set_plan(TIMEOUT + 5, 0, 0, 0);
    fetch(32'h0000_0300, 32'h0BAD_0BAD);

    // Timeout after two good bytes.
    set_plan(0, 1, TIMEOUT, 0);
    fetch(32'h0000_0400, 32'h1111_2222);

    // Just under the timeout still completes.
    set_plan(TIMEOUT - 1, 0, TIMEOUT - 1, 2);
    fetch(32'h0000_0500, 32'hA5A5_5A5A);

    // Reset in the middle of a fetch, after the second byte.
    @(negedge CLK);
    pc_addr = 32'h0000_0600; fetch_req = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    fetch_req = 1'b0; bus.mem_ready = 1'b1; bus.mem_data = 8'hAA;
    @(posedge CLK);
    @(negedge CLK);
    bus.mem_data = 8'hBB;
    @(posedge CLK);
    @(negedge CLK);
    bus.mem_ready = 1'b0;
    Reset = 1'b1;
    model_instr = '0;
    model_addr  = '0;
    #1 check_idle("mid_reset");
    check("mid_reset_state", dbg_state, 0);
    @(negedge CLK);
    check_idle("reset_hold");
    Reset = 1'b0;
    @(negedge CLK);
    check_idle("reset_release");
    set_plan(0, 0, 0, 0);
    fetch(32'h0000_0104, 32'h0F1E_2D3C);

    // Randomized fetches.
    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < 4; i++) plan[i] = $urandom_range(0, 4);
      if ($urandom_range(0, 4) == 0) plan[$urandom_range(0, 3)] = $urandom_range(TIMEOUT, TIMEOUT + 3);
      fetch($urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a stuck simulation.
  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum wait cycles per byte for mem_ready; range 1..255.
REQ-002 CLK  input  1  clock; all state updates on rising edge.
REQ-003 Reset  input  1  reset, asynchronous, active-high.
REQ-004 pc_addr  input  32  byte address of instruction to fetch (program counter output).
REQ-005 fetch_req  input  1  fetch request; sampled only in IDLE.
REQ-006 mem_addr  output  32  byte address presented to instruction memory.
REQ-007 mem_rd  output  1  memory read strobe.
REQ-008 mem_data  input  8  byte returned by memory; valid when mem_ready=1.
REQ-009 mem_ready  input  1  memory byte-valid acknowledge.
REQ-010 instr  output  32  assembled instruction word.
REQ-011 instr_valid  output  1  one-cycle pulse: instr updated and valid.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 fetch_err  output  1  one-cycle pulse: fetch aborted.

Function
REQ-014 FSM states SHALL be IDLE, READ, DONE, ERR; all outputs registered or decoded from registered state.
REQ-015 IDLE: on fetch_req=1, SHALL latch pc_addr into base, clear byte index and wait counter, go to READ; fetch_req=0 stays in IDLE.
REQ-016 READ: mem_rd SHALL be 1 and mem_addr SHALL equal base + index (32-bit modulo; 0xFFFFFFFF+1 wraps to 0x00000000).
REQ-017 READ with mem_ready=1: SHALL capture mem_data big-endian (index 0 -> instr[31:24], 3 -> instr[7:0]), clear wait counter; index 3 -> DONE, else index+1 and stay.
REQ-018 READ with mem_ready=0: wait counter +1; when counter reaches TIMEOUT -> ERR with no byte captured.
REQ-019 DONE: instr_valid=1 for exactly one cycle, then IDLE; fetch_req in DONE SHALL be ignored.
REQ-020 ERR: fetch_err=1 for exactly one cycle, then IDLE; instr SHALL keep its last completed value (partial bytes held in a shadow register, committed only on entering DONE).
REQ-021 Latency with mem_ready held 1: fetch_req sampled at edge N -> instr_valid high between edges N+4 and N+5.
REQ-022 fetch_req while busy SHALL be ignored and SHALL NOT be queued.
REQ-023 mem_rd SHALL be 0 and mem_addr SHALL hold last driven value outside READ.
REQ-024 instr_valid and fetch_err SHALL never be asserted in the same cycle.

Reset
REQ-025 Reset=1 SHALL immediately force IDLE, instr=0, shadow=0, base=0, index=0, wait counter=0, mem_addr=0, mem_rd=0, instr_valid=0, fetch_err=0, busy=0.
REQ-026 Reset asserted mid-READ SHALL abandon the fetch with no instr_valid or fetch_err pulse; first fetch after release starts at index 0.

Configuration
REQ-027 Macro FETCH_ALIGN_CHECK_EN defined: in IDLE, fetch_req=1 with pc_addr[1:0]!=0 SHALL go directly to ERR (no mem_rd asserted), fetch_err pulses one cycle later.
REQ-028 Macro FETCH_ALIGN_CHECK_EN undefined: misaligned pc_addr SHALL be fetched normally from base+0..base+3.

Verification
REQ-029 Reset, pc_addr=0x100, fetch_req 1 cycle, mem_ready=1, bytes 0x8C,0x01,0x00,0x04 -> mem_addr 0x100..0x103, instr=0x8C010004, instr_valid 1 cycle at edge N+4.
REQ-030 mem_ready low 3 cycles before each byte, TIMEOUT=15 -> instr_valid after 16 cycles, correct word, no fetch_err.
REQ-031 mem_ready never asserted, TIMEOUT=15 -> fetch_err pulse after 15 wait cycles, instr unchanged from prior fetch, busy drops next cycle.
REQ-032 pc_addr=0xFFFFFFFE, no align check -> mem_addr sequence 0xFFFFFFFE,0xFFFFFFFF,0x00000000,0x00000001.
REQ-033 pc_addr=0x102 with FETCH_ALIGN_CHECK_EN -> no mem_rd, fetch_err pulse, instr unchanged.
REQ-034 Reset asserted after 2nd byte -> all outputs 0 immediately, no pulses; subsequent fetch of 0x104 completes normally.
